// File: rtl/vram_fetch.sv
// vram_fetch: fetches four bit-planes per display request over a shared byte-wide
// memory port, with lower-priority CPU accesses and a display deadline monitor.
module vram_fetch #(
  parameter int         DEADLINE   = 24,
  parameter logic [2:0] PLANE_BASE = 3'b100
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic [12:0] vaddr,
  output logic [31:0] vdata,
  output logic        vdata_valid,
  output logic [7:0]  underrun_cnt,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);
  typedef enum logic [2:0] {IDLE = 3'd0, V0 = 3'd1, V1 = 3'd2, V2 = 3'd3, V3 = 3'd4, CPU = 3'd5} state_t;
  localparam logic [7:0] DL = 8'(DEADLINE);
  state_t      r_state, w_next;
  logic        r_pend, r_cpu_we, r_rd, r_we, r_vvalid, r_cpu_ack, r_dl_on;
  logic [12:0] r_pend_addr, r_cur_addr;
  logic [23:0] r_shadow;
  logic [15:0] r_cpu_addr;
  logic [7:0]  r_cpu_din, r_cpu_dout, r_dl, r_ur;
  logic [31:0] r_vdata;
  logic        w_ack, w_vid, w_grant, w_commit, w_cpu_done;
  logic [1:0]  w_k;
  // An ack only counts while a strobe is out, so acks left over from a reset are dropped.
  assign w_ack      = mem_ack & (r_rd | r_we);
  assign w_vid      = r_state inside {V0, V1, V2, V3};
  assign w_k        = 2'(r_state - 3'd1);
  assign w_grant    = (r_state == IDLE) & (r_pend | fetch_req);
  assign w_commit   = (r_state == V3) & w_ack;
  assign w_cpu_done = (r_state == CPU) & w_ack;
  assign mem_addr     = w_vid ? {PLANE_BASE[2], w_k, r_cur_addr} : (r_state == CPU) ? r_cpu_addr : 16'h0;
  assign mem_rd       = r_rd;
  assign mem_we       = r_we;
  assign mem_wdata    = r_cpu_din;
  assign vdata        = r_vdata;
  assign vdata_valid  = r_vvalid;
  assign cpu_dout     = r_cpu_dout;
  assign cpu_ack      = r_cpu_ack;
  assign underrun_cnt = r_ur;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       w_next = w_grant ? V0 : cpu_req ? CPU : IDLE;
      V0, V1, V2: w_next = w_ack ? state_t'(r_state + 3'd1) : r_state;
      V3, CPU:    w_next = w_ack ? IDLE : r_state;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_cur_addr  <= '0;
      r_cpu_addr  <= '0;
      r_cpu_we    <= 1'b0;
      r_cpu_din   <= '0;
      r_rd        <= 1'b0;
      r_we        <= 1'b0;
      r_shadow    <= '0;
      r_vdata     <= '0;
      r_vvalid    <= 1'b0;
      r_cpu_dout  <= '0;
      r_cpu_ack   <= 1'b0;
      r_dl        <= '0;
      r_dl_on     <= 1'b0;
      r_ur        <= '0;
    end else begin
      r_pend <= w_grant ? (r_pend & fetch_req) : (r_pend | fetch_req);
      if (fetch_req) r_pend_addr <= vaddr;
      if (w_grant) r_cur_addr <= r_pend ? r_pend_addr : vaddr;
      if (r_state == IDLE && !w_grant && cpu_req) begin
        r_cpu_addr <= cpu_addr;
        r_cpu_we   <= cpu_we;
        r_cpu_din  <= cpu_din;
      end
      // Strobes rise one cycle into each state and fall the cycle after the ack.
      r_rd <= ~w_ack & (w_vid | ((r_state == CPU) & ~r_cpu_we));
      r_we <= ~w_ack & (r_state == CPU) & r_cpu_we;
      if (w_ack && w_vid && !w_commit) r_shadow <= {r_shadow[15:0], mem_rdata};
      r_vvalid <= w_commit;
      if (w_commit) r_vdata <= {r_shadow, mem_rdata};
      r_cpu_ack <= w_cpu_done;
      if (w_cpu_done && !r_cpu_we) r_cpu_dout <= mem_rdata;
      // The deadline tracks the most recently accepted fetch; it retires once no fetch remains queued.
      if (fetch_req) begin
        r_dl    <= DL;
        r_dl_on <= 1'b1;
      end else if (r_dl_on) begin
        if (w_commit && !r_pend) r_dl_on <= 1'b0;
        else if (r_dl != 8'd0) begin
          r_dl <= r_dl - 8'd1;
          if (r_dl == 8'd1 && r_ur != 8'hff) r_ur <= r_ur + 8'd1;
        end
      end
    end
  end
endmodule
